// File: rtl/sum_ascii_pkg.sv
// Shared types and constants for the sum-to-ASCII pacing stage.
package sum_ascii_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        SEND = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    // One UART frame (start + 8 data + stop) plus one guard bit, in clocks.
    function automatic int unsigned byte_cyc_f(input int unsigned clk_freq,
                                               input int unsigned uart_bps);
        return 32'd11 * (clk_freq / uart_bps);
    endfunction

    function automatic logic [7:0] digit_ascii(input logic [3:0] digit);
        return ASCII_0 + {4'd0, digit};
    endfunction

endpackage

// File: rtl/sum_ascii_tx_bin2dec_seq.sv
// Iterative binary-to-decimal converter: one subtract step per cycle after start,
// then one cycle to raise done once the remainder is below ten.
module bin2dec_seq
    import sum_ascii_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] value,
    output logic       done,
    output logic [1:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [7:0] work_r;
    logic       run_r;

    assign ones = work_r[3:0];

    // Load on start, then peel off hundreds before tens until the remainder is a single digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_r   <= 8'd0;
            run_r    <= 1'b0;
            done     <= 1'b0;
            hundreds <= 2'd0;
            tens     <= 4'd0;
        end else if (start) begin
            work_r   <= value;
            run_r    <= 1'b1;
            done     <= 1'b0;
            hundreds <= 2'd0;
            tens     <= 4'd0;
        end else if (run_r) begin
            if (work_r >= 8'd100) begin
                work_r   <= work_r - 8'd100;
                hundreds <= hundreds + 2'd1;
            end else if (work_r >= 8'd10) begin
                work_r <= work_r - 8'd10;
                tens   <= tens + 4'd1;
            end else begin
                run_r <= 1'b0;
                done  <= 1'b1;
            end
        end else begin
            done <= done;
        end
    end

endmodule

// File: rtl/sum_ascii_tx.sv
// Queues 8-bit sums, formats each as three ASCII digits plus a terminator and
// paces one byte strobe per UART frame. SUM_ASCII_CRLF_EN selects CR LF instead of a space.
module sum_ascii_tx
    import sum_ascii_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int UART_BPS = 9600,
    parameter int DEPTH    = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pi_flag,
    input  logic [7:0] pi_sum,
    output logic       po_flag,
    output logic [7:0] po_data,
    output logic       po_drop,
    output logic       busy
);

    localparam int BYTE_CYC = int'(byte_cyc_f(CLK_FREQ, UART_BPS));
    localparam int CW       = $clog2(BYTE_CYC);
    localparam int AW       = $clog2(DEPTH);
`ifdef SUM_ASCII_CRLF_EN
    localparam int NCHAR = 5;
`else
    localparam int NCHAR = 4;
`endif
    localparam logic [2:0]    LAST_IDX = 3'(NCHAR - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BYTE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
    localparam logic [AW:0]   FILL_ONE = (AW+1)'(1'b1);
    localparam logic [AW:0]   FILL_MAX = (AW+1)'(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          full_s;
    logic          empty_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    state_t        state_r;
    logic [2:0]    idx_r;
    logic [CW-1:0] cnt_r;
    logic [7:0]    chars_r [5];

    logic          conv_done_s;
    logic [1:0]    conv_hund_s;
    logic [3:0]    conv_tens_s;
    logic [3:0]    conv_ones_s;

    assign full_s  = (count_r == FILL_MAX);
    assign empty_s = (count_r == {(AW+1){1'b0}});
    // A pop frees a slot in the same edge, so a full queue still accepts a write then.
    assign pop_s   = (state_r == IDLE) && !empty_s;
    assign push_s  = pi_flag && (!full_s || pop_s);
    assign drop_s  = pi_flag && full_s && !pop_s;

    // Queue storage; contents need no reset because count_r gates every read.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= pi_sum;
        end
    end

    // Queue pointers, fill level and the registered drop pulse.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            po_drop  <= 1'b0;
        end else begin
            po_drop <= drop_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + FILL_ONE;
                2'b01:   count_r <= count_r - FILL_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    bin2dec_seq u_bin2dec (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .start    (pop_s),
        .value    (mem_r[rd_ptr_r]),
        .done     (conv_done_s),
        .hundreds (conv_hund_s),
        .tens     (conv_tens_s),
        .ones     (conv_ones_s)
    );

    // Pacing FSM: convert, then strobe one character per frame time.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= IDLE;
            idx_r   <= 3'd0;
            cnt_r   <= {CW{1'b0}};
            po_flag <= 1'b0;
            po_data <= 8'd0;
            busy    <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                chars_r[i] <= 8'd0;
            end
        end else begin
            po_flag <= 1'b0;
            busy    <= (state_r != IDLE) || !empty_s;
            case (state_r)
                IDLE: begin
                    idx_r <= 3'd0;
                    if (pop_s) begin
                        state_r <= CONV;
                    end
                end
                CONV: begin
                    if (conv_done_s) begin
                        chars_r[0] <= digit_ascii({2'b00, conv_hund_s});
                        chars_r[1] <= digit_ascii(conv_tens_s);
                        chars_r[2] <= digit_ascii(conv_ones_s);
`ifdef SUM_ASCII_CRLF_EN
                        chars_r[3] <= ASCII_CR;
                        chars_r[4] <= ASCII_LF;
`else
                        chars_r[3] <= ASCII_SP;
                        chars_r[4] <= ASCII_SP;
`endif
                        state_r <= SEND;
                    end
                end
                SEND: begin
                    po_flag <= 1'b1;
                    po_data <= chars_r[idx_r];
                    cnt_r   <= {CW{1'b0}};
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= {CW{1'b0}};
                        if (idx_r == LAST_IDX) begin
                            state_r <= IDLE;
                        end else begin
                            idx_r   <= idx_r + 3'd1;
                            state_r <= SEND;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sum_ascii_tx.md
# sum_ascii_tx

Formatting and pacing stage between `fifo_sum_ctrl` and `uart_tx` in the FIFO-sum design. It accepts each 8-bit column sum as a single-cycle strobe and buffers it in a small queue. It converts each sum to three ASCII decimal digits plus a terminator, then issues one byte strobe per UART frame time, so `uart_tx` is never re-triggered while a frame is still being transmitted. This makes sums readable in a serial terminal.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `UART_BPS`, 9600: baud rate of the downstream `uart_tx`.
- `DEPTH`, 4: input queue depth in entries. Must be a power of two, at least 2.
- `sys_clk` in 1: system clock; the only clock.
- `sys_rst` in 1: reset; synchronous, active-high.
- `pi_flag` in 1: single-cycle strobe meaning `pi_sum` is valid.
- `pi_sum` in 8: unsigned sum from `fifo_sum_ctrl`.
- `po_flag` out 1: single-cycle strobe to `uart_tx` `pi_flag`.
- `po_data` out 8: ASCII byte; valid on `po_flag` and held until the next strobe.
- `po_drop` out 1: single-cycle pulse when an input is lost because the queue is full.
- `busy` out 1: high while not in IDLE or while the queue is non-empty.

## Operation
- **Reset values.** All outputs are 0. The queue is empty, the state is IDLE, and all counters are 0.
- **Queue.** `pi_flag` writes `pi_sum` at the clock edge.
  - Full and no pop in the same cycle: the write is discarded and `po_drop` pulses in the next cycle.
  - Full with a pop in the same cycle: the write is accepted.
- **IDLE.** When the queue is non-empty, pop the head into the work register and go to CONV.
- **CONV.** One cycle per step, in this order:
  - subtract 100 while the value is ≥ 100 (0–2 steps), counting the hundreds digit;
  - then subtract 10 while the value is ≥ 10 (0–9 steps), counting the tens digit;
  - the remainder is the ones digit;
  - one final cycle latches the character buffer, then go to SEND.
- **Character buffer.**
  - Digits are `0x30 + digit`, most significant first, always three digits with leading zeros.
  - The terminator follows per Configuration.
- **SEND.** Drive `po_data` with the current character and pulse `po_flag` for one cycle, then go to WAIT.
- **WAIT.** Count `BYTE_CYC` cycles, where `BYTE_CYC = 11 * (CLK_FREQ / UART_BPS)` (one frame plus one guard bit).
  - If characters remain, go to SEND with the index incremented.
  - Otherwise go to IDLE.
- **Arithmetic.** The work value is 8 bits, the hundreds count 2 bits, the tens count 4 bits, and the wait counter `$clog2(BYTE_CYC)` bits. Integer division truncates.
- **Reset mid-operation.** Abort at once. No further `po_flag`, and the queue contents are lost. A frame already started in `uart_tx` is not this block's concern.

## Timing
- `pi_flag` into an empty queue in IDLE:
  - the entry pops on the next cycle;
  - the first `po_flag` follows within 14 cycles of `pi_flag`;
  - exact CONV length is `2 + hundreds + tens` cycles.
- Consecutive `po_flag` pulses within one value are exactly `BYTE_CYC + 1` cycles apart.
- The next value's CONV starts 1 cycle after the last WAIT ends.
- `po_flag` is never high on two consecutive cycles.
- `pi_flag` is accepted on every cycle; no back-pressure.

## Configuration
- `SUM_ASCII_CRLF_EN` defined: the terminator is `0x0D 0x0A`, giving 5 characters per value.
- `SUM_ASCII_CRLF_EN` undefined: the terminator is `0x20` (space), giving 4 characters per value.

## Structure
- Package `sum_ascii_pkg` holds:
  - the state enum (IDLE, CONV, SEND, WAIT);
  - ASCII constants (`ASCII_0`, `ASCII_CR`, `ASCII_LF`, `ASCII_SP`);
  - the `BYTE_CYC` computation function.
- One sub-module, `bin2dec_seq`, contains the iterative subtract converter with start/done handshake and digit outputs. The queue and pacing FSM stay in the top module.

## Test plan
- Use `CLK_FREQ=1000` and `UART_BPS=100`, so `BYTE_CYC=110`. `SUM_ASCII_CRLF_EN` is defined unless stated otherwise.
- `pi_sum=123` → `po_data` sequence 0x31 0x32 0x33 0x0D 0x0A, strobes 111 cycles apart, first strobe within 14 cycles.
- `pi_sum=0` then `pi_sum=255`, 2 cycles apart → 0x30 0x30 0x30 0x0D 0x0A, then 0x32 0x35 0x35 0x0D 0x0A, no `po_drop`.
- 6 `pi_flag` pulses on consecutive cycles, values 1–6 → values 1–5 transmitted in order; value 6 dropped with one `po_drop` pulse.
- `sys_rst` asserted 20 cycles after the second `po_flag` of value 200 → no further `po_flag`, all outputs 0 next cycle, `busy=0`. A new `pi_sum=7` then yields 0x30 0x30 0x37 0x0D 0x0A.
- With `SUM_ASCII_CRLF_EN` undefined, `pi_sum=42` → 0x30 0x34 0x32 0x20, then `busy` falls 110 cycles after the last strobe plus 1.
